// File: rtl/cc_event_pacer.sv
`default_nettype none
// ============================================================================
// Module      : cc_event_pacer
// Description : Source-domain feeder for a cross-clock event handshake.
//               Counts incoming single-cycle event pulses and releases them
//               one at a time whenever the handshake stage is not busy.
//               Flags counter saturation (dropped events) and a handshake
//               stage that never acknowledges an issue with busy.
// Revision    : 1.0 - initial release
// ============================================================================
module cc_event_pacer #(
  parameter int CNT_W  = 8,  // pending counter width, capacity 2^CNT_W-1
  parameter int GAP    = 0,  // extra idle cycles after busy falls (0..255)
  parameter int ARM_TO = 4   // cycles to wait for busy to rise (>=2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             evt_in,
  input  logic             evt_busy,
  input  logic             flag_clr,
  output logic             evt_out,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             timeout,
  output logic             idle
);

  localparam int               TO_W     = $clog2(ARM_TO + 1);
  localparam logic [TO_W-1:0]  C_ARM_TO = TO_W'(ARM_TO);
  localparam logic [7:0]       C_GAP    = 8'(GAP);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_DRAIN = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [TO_W-1:0]  w_to_cnt_nxt;
  logic [7:0]       r_gap_cnt;
  logic [7:0]       w_gap_cnt_nxt;
  logic             w_to_set;

  logic [CNT_W-1:0] r_pending;
  logic [CNT_W-1:0] w_pending_nxt;
  logic             r_overflow;
  logic             r_timeout;
  logic             w_inc;
  logic             w_dec;
  logic             w_drop;

  // State register plus the ARM timeout and HOLD gap counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  // Next-state decision; issue is only launched from a registered IDLE state
  always_comb begin
    w_state_nxt   = r_state;
    w_to_cnt_nxt  = r_to_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_to_set      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_pending != '0) && !evt_busy) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // ARM counts its own cycles starting from 1
        w_state_nxt  = S_ARM;
        w_to_cnt_nxt = TO_W'(1);
      end
      S_ARM: begin
        if (evt_busy) begin
          w_state_nxt = S_DRAIN;
        end else if (r_to_cnt == C_ARM_TO) begin
          w_to_set      = 1'b1;
          w_state_nxt   = S_HOLD;
          w_gap_cnt_nxt = '0;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end
      S_DRAIN: begin
        if (!evt_busy) begin
          w_state_nxt   = S_HOLD;
          w_gap_cnt_nxt = '0;
        end
      end
      S_HOLD: begin
        // HOLD lasts GAP+1 cycles
        if (r_gap_cnt == C_GAP) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Pending-count update; a saturated counter drops the incoming event
  always_comb begin
    w_inc         = evt_in;
    w_dec         = (r_state == S_ISSUE);
    w_drop        = w_inc && !w_dec && (r_pending == C_CNT_MAX);
    w_pending_nxt = r_pending;
    if (w_inc && !w_dec && !w_drop) begin
      w_pending_nxt = r_pending + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (w_dec && !w_inc) begin
      w_pending_nxt = r_pending - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Pending counter and sticky flags; a set beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_pending  <= w_pending_nxt;
      r_overflow <= w_drop   || (r_overflow && !flag_clr);
      r_timeout  <= w_to_set || (r_timeout  && !flag_clr);
    end
  end

  assign evt_out  = (r_state == S_ISSUE);
  assign pending  = r_pending;
  assign overflow = r_overflow;
  assign timeout  = r_timeout;
  assign idle     = (r_state == S_IDLE) && (r_pending == '0);

endmodule
`default_nettype wire

// File: tb/tb_cc_event_pacer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cc_event_pacer
// Description : Self-checking bench for cc_event_pacer. A default instance
//               runs against a busy model that answers each issue with a
//               fixed-width busy pulse; a CNT_W=3 instance covers saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_event_pacer;

  localparam int BW = 6;  // busy pulse width of the handshake model

  logic       clk = 1'b0;
  logic       rst_n, evt_in, evt_busy, flag_clr;
  logic       evt_out, overflow, timeout, idle;
  logic [7:0] pending;

  logic       s_rst_n, s_evt_in, s_busy, s_flag_clr;
  logic       s_evt_out, s_overflow, s_timeout, s_idle;
  logic [2:0] s_pending;

  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  int busy_mode = 0;  // 0: model, 1: forced high, 2: forced low
  int bcnt = 0;
  bit bm_start = 1'b0;
  bit bw_active = 1'b0;

  int pulse_cnt = 0;
  int s_pulse_cnt = 0;
  int zero_dec = 0;
  bit spacing_en = 1'b0;
  int last_pulse = -1;
  int min_gap = 1000000;
  int max_gap = 0;
  bit peak_en = 1'b0;
  int peak = 0;

  typedef struct {
    logic evt;
    logic exp_out;
    int   exp_pend;
    logic exp_idle;
  } vec_t;

  vec_t tbl[25];

  cc_event_pacer #(.CNT_W(8), .GAP(0), .ARM_TO(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .evt_in   (evt_in),
    .evt_busy (evt_busy),
    .flag_clr (flag_clr),
    .evt_out  (evt_out),
    .pending  (pending),
    .overflow (overflow),
    .timeout  (timeout),
    .idle     (idle)
  );

  cc_event_pacer #(.CNT_W(3), .GAP(2), .ARM_TO(4)) u_sat (
    .clk      (clk),
    .rst_n    (s_rst_n),
    .evt_in   (s_evt_in),
    .evt_busy (s_busy),
    .flag_clr (s_flag_clr),
    .evt_out  (s_evt_out),
    .pending  (s_pending),
    .overflow (s_overflow),
    .timeout  (s_timeout),
    .idle     (s_idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake model: busy rises the cycle after an issue and lasts BW cycles
  always @(negedge clk) begin
    if (bm_start) bcnt = BW;
    bm_start = evt_out;
    if (bcnt > 0) begin
      bw_active = 1'b1;
      bcnt = bcnt - 1;
    end else begin
      bw_active = 1'b0;
    end
    evt_busy = (busy_mode == 1) ? 1'b1 : (busy_mode == 2) ? 1'b0 : bw_active;
  end

  // Pulse bookkeeping: counts, spacing, pending peak, issue-with-empty events
  always @(negedge clk) begin
    if (evt_out) begin
      pulse_cnt = pulse_cnt + 1;
      if (pending == 8'd0) zero_dec = zero_dec + 1;
      if (spacing_en && last_pulse >= 0) begin
        if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
        if (cyc - last_pulse > max_gap) max_gap = cyc - last_pulse;
      end
      last_pulse = cyc;
    end
    if (!spacing_en) begin
      last_pulse = -1;
      min_gap = 1000000;
      max_gap = 0;
    end
    if (s_evt_out) begin
      s_pulse_cnt = s_pulse_cnt + 1;
      if (s_pending == 3'd0) zero_dec = zero_dec + 1;
    end
    if (peak_en) begin
      if (int'(pending) > peak) peak = int'(pending);
    end else begin
      peak = 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!idle && n < budget) begin
      @(negedge clk);
      n = n + 1;
    end
    check(name, int'(idle), 1);
  endtask

  // Global time limit so the run always ends
  initial begin
    #200us;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst_n = 1'b0; evt_in = 1'b0; flag_clr = 1'b0;
    s_rst_n = 1'b0; s_evt_in = 1'b0; s_busy = 1'b1; s_flag_clr = 1'b0;
    evt_busy = 1'b0;

    // Single-event table: event at row 2, a second one during DRAIN at row 6
    for (int i = 0; i < 25; i++) tbl[i] = '{1'b0, 1'b0, 0, 1'b0};
    for (int i = 0; i <= 2; i++) tbl[i].exp_idle = 1'b1;
    tbl[2].evt = 1'b1;
    tbl[3].exp_pend = 1;
    tbl[4].exp_pend = 1;
    tbl[4].exp_out  = 1'b1;
    tbl[6].evt = 1'b1;
    for (int i = 7; i <= 14; i++) tbl[i].exp_pend = 1;
    tbl[14].exp_out = 1'b1;
    tbl[23].exp_idle = 1'b1;
    tbl[24].exp_idle = 1'b1;

    repeat (10) @(negedge clk);
    check("rst_pending", int'(pending), 0);
    check("rst_idle", int'(idle), 1);
    check("rst_evt_out", int'(evt_out), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_s_idle", int'(s_idle), 1);
    rst_n = 1'b1;
    s_rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check($sformatf("row%0d_evt_out", i), int'(evt_out), int'(tbl[i].exp_out));
      check($sformatf("row%0d_pending", i), int'(pending), tbl[i].exp_pend);
      check($sformatf("row%0d_idle", i), int'(idle), int'(tbl[i].exp_idle));
      evt_in = tbl[i].evt;
    end
    check("single_overflow", int'(overflow), 0);
    check("single_timeout", int'(timeout), 0);

    // Burst of five events, busy width 6, GAP 0 -> pulses every 10 cycles
    base = pulse_cnt;
    spacing_en = 1'b1;
    peak_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      evt_in = 1'b1;
    end
    @(negedge clk);
    evt_in = 1'b0;
    @(negedge clk);
    wait_idle("burst_idle", 200);
    check("burst_pulses", pulse_cnt - base, 5);
    check("burst_min_gap", min_gap, 10);
    check("burst_max_gap", max_gap, 10);
    check("burst_peak_4_or_5", int'(peak == 4 || peak == 5), 1);
    check("burst_pending_end", int'(pending), 0);
    spacing_en = 1'b0;
    peak_en = 1'b0;
    repeat (3) @(negedge clk);

    // Event arriving on the ISSUE cycle keeps pending at 1
    base = pulse_cnt;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      evt_in = 1'b0;
      case (c)
        0: evt_in = 1'b1;
        1: check("sim_pending_c1", int'(pending), 1);
        2: begin
          check("sim_issue_c2", int'(evt_out), 1);
          evt_in = 1'b1;
        end
        3: begin
          check("sim_pending_c3", int'(pending), 1);
          check("sim_no_out_c3", int'(evt_out), 0);
        end
        default: ;
      endcase
    end
    @(negedge clk);
    wait_idle("sim_idle", 200);
    check("sim_pulses", pulse_cnt - base, 2);

    // Busy never rises: timeout, reissue, clear, and set-beats-clear
    busy_mode = 2;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      evt_in = 1'b0;
      flag_clr = 1'b0;
      case (c)
        0: evt_in = 1'b1;
        1: evt_in = 1'b1;
        2: begin
          check("to_issue1", int'(evt_out), 1);
          check("to_flag_c2", int'(timeout), 0);
        end
        3: check("to_pending_c3", int'(pending), 1);
        6: check("to_flag_c6", int'(timeout), 0);
        7: check("to_flag_c7", int'(timeout), 1);
        9: begin
          check("to_reissue_c9", int'(evt_out), 1);
          flag_clr = 1'b1;
        end
        10: check("to_cleared_c10", int'(timeout), 0);
        13: flag_clr = 1'b1;
        14: check("to_set_beats_clr", int'(timeout), 1);
        15: check("to_idle_c15", int'(idle), 1);
        default: ;
      endcase
    end
    @(negedge clk);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    busy_mode = 0;
    repeat (10) @(negedge clk);

    // Reset while draining with three events still pending
    base = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      evt_in = (c < 4) ? 1'b1 : 1'b0;
      if (c == 5) begin
        check("rd_pending_c5", int'(pending), 3);
        check("rd_busy_c5", int'(idle), 0);
        base = pulse_cnt;
        rst_n = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rd_pending", int'(pending), 0);
    check("rd_idle", int'(idle), 1);
    check("rd_overflow", int'(overflow), 0);
    check("rd_timeout", int'(timeout), 0);
    repeat (30) @(negedge clk);
    check("rd_no_pulses", pulse_cnt - base, 0);

    // Saturation on the 3-bit instance with busy held high
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      s_evt_in = 1'b1;
    end
    @(negedge clk);
    s_evt_in = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_pending", int'(s_pending), 7);
    check("sat_overflow", int'(s_overflow), 1);
    check("sat_no_pulses", s_pulse_cnt, 0);
    s_busy = 1'b0;
    repeat (3) @(negedge clk);
    n = 0;
    while (!s_idle && n < 300) begin
      @(negedge clk);
      n = n + 1;
    end
    check("sat_idle", int'(s_idle), 1);
    check("sat_pulses", s_pulse_cnt, 7);
    check("sat_pending_end", int'(s_pending), 0);
    check("sat_timeout", int'(s_timeout), 1);
    s_flag_clr = 1'b1;
    @(negedge clk);
    s_flag_clr = 1'b0;
    @(negedge clk);
    check("sat_ovf_cleared", int'(s_overflow), 0);
    check("sat_to_cleared", int'(s_timeout), 0);

    check("no_issue_when_empty", zero_dec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
